wb_arbiter_wdt: RTL and testbench

// - Round-robin Wishbone bus arbiter with a per-transfer watchdog. It sits between the masters' cyc/stb lines and the shared intercon mux.
// - Owns grant sequencing: the intercon uses gnt_idx_o to steer adr/dat/sel/we and ack/err.
// - Terminates a master's stalled transfer with a synthesized error when the addressed slave never answers.

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_rr_pick.sv | 24 ++
 rtl/wb_arbiter_wdt.sv | 112 +++++++++++
 tb/tb_wb_arbiter_wdt.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone arbiter: FSM state encodings and bus widths.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_ABORT   = 2'd2
    } arb_state_e;

    // Kept next to the Wishbone width defines used by the intercon mux.
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = WB_DAT_W / 8;

    localparam int TO_COUNT_W = 8;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req_i scanning ptr_i, ptr_i+1, ... modulo N.
module wb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) begin
                idx_o   = IDX_W'((int'(ptr_i) + i) % N);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_wdt.sv
// Round-robin Wishbone arbiter; a watchdog aborts a granted transfer whose strobe stalls for TIMEOUT cycles.
module wb_arbiter_wdt
    import wb_arb_pkg::*;
#(
    parameter int MASTERS_NUM = 2,
    parameter int TIMEOUT     = 255,
    parameter int IDX_W       = $clog2(MASTERS_NUM),
    parameter int TO_W        = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [MASTERS_NUM-1:0] cyc_i,
    input  logic [MASTERS_NUM-1:0] stb_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    output logic [MASTERS_NUM-1:0] gnt_o,
    output logic [IDX_W-1:0]       gnt_idx_o,
    output logic                   gnt_valid_o,
    output logic                   to_err_o,
    output logic [TO_COUNT_W-1:0]  to_count_o,
    output logic [1:0]             state_o
);

    localparam int               TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MASTERS_NUM - 1);

    arb_state_e             state_q;
    logic [MASTERS_NUM-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       idx_q, ptr_q, ptr_d;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic [TO_W-1:0]        wdt_q;
    logic                   to_err_q;
    logic [TO_COUNT_W-1:0]  to_count_q;

    wb_rr_pick #(
        .N     (MASTERS_NUM),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (cyc_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign gnt_d = MASTERS_NUM'(1) << pick_idx;
    // The master being released drops to lowest priority.
    assign ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            wdt_q      <= '0;
            to_err_q   <= 1'b0;
            to_count_q <= '0;
        end else begin
            to_err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= gnt_d;
                        idx_q   <= pick_idx;
                        wdt_q   <= '0;
                        state_q <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (!cyc_i[idx_q]) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= ARB_IDLE;
                    end else if (ack_i || err_i) begin
                        wdt_q <= '0;
                    end else if (stb_i[idx_q] && (TIMEOUT != 0)) begin
                        if (wdt_q == TO_W'(TO_LAST)) begin
                            to_err_q <= 1'b1;
                            if (to_count_q != '1) begin
                                to_count_q <= to_count_q + 1'b1;
                            end
                            wdt_q   <= '0;
                            state_q <= ARB_ABORT;
                        end else begin
                            wdt_q <= wdt_q + 1'b1;
                        end
                    end
                end
                ARB_ABORT: begin
                    if (!cyc_i[idx_q]) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = |gnt_q;
    assign to_err_o    = to_err_q;
    assign to_count_o  = to_count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_wb_arbiter_wdt.sv
// Directed bench: two-master arbiters (TIMEOUT=4 and TIMEOUT=0) sharing stimulus, plus a three-master instance.
module tb_wb_arbiter_wdt;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] cyc = '0, stb = '0;
  logic ack = 1'b0, err = 1'b0;

  logic [1:0] gnt_a, gnt_z, st_a, st_z;
  logic       idx_a, idx_z, val_a, val_z, te_a, te_z;
  logic [7:0] cnt_a, cnt_z;

  logic [2:0] cyc3 = '0;
  logic [2:0] gnt_c;
  logic [1:0] idx_c, st_c;
  logic       val_c, te_c;
  logic [7:0] cnt_c;

  wb_arbiter_wdt #(.MASTERS_NUM(2), .TIMEOUT(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .ack_i(ack), .err_i(err),
    .gnt_o(gnt_a), .gnt_idx_o(idx_a), .gnt_valid_o(val_a), .to_err_o(te_a),
    .to_count_o(cnt_a), .state_o(st_a)
  );

  wb_arbiter_wdt #(.MASTERS_NUM(2), .TIMEOUT(0)) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .ack_i(ack), .err_i(err),
    .gnt_o(gnt_z), .gnt_idx_o(idx_z), .gnt_valid_o(val_z), .to_err_o(te_z),
    .to_count_o(cnt_z), .state_o(st_z)
  );

  wb_arbiter_wdt #(.MASTERS_NUM(3)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc3), .stb_i(3'b000), .ack_i(1'b0), .err_i(1'b0),
    .gnt_o(gnt_c), .gnt_idx_o(idx_c), .gnt_valid_o(val_c), .to_err_o(te_c),
    .to_count_o(cnt_c), .state_o(st_c)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] tcyc [0:10] = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011,
                              3'b111, 3'b110, 3'b100, 3'b011, 3'b010};
  logic [2:0] texp [0:10] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                              3'b001, 3'b000, 3'b100, 3'b000, 3'b010};

  int z_err_seen;

  initial begin
    // reset values, asserted asynchronously
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_gnt", gnt_a, 2'b00);
    check_val("rst_idx", idx_a, 1'b0);
    check_val("rst_valid", val_a, 1'b0);
    check_val("rst_to_err", te_a, 1'b0);
    check_val("rst_to_count", cnt_a, 8'd0);
    check_val("rst_state", st_a, 2'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // single requester, then release moves priority to master 0
    cyc = 2'b10;
    step();
    check_val("req1_gnt", gnt_a, 2'b10);
    check_val("req1_idx", idx_a, 1'b1);
    check_val("req1_valid", val_a, 1'b1);
    check_val("req1_state", st_a, 2'd1);
    cyc = 2'b00;
    step();
    check_val("rel1_gnt", gnt_a, 2'b00);
    check_val("rel1_state", st_a, 2'd0);
    check_val("rel1_idx_hold", idx_a, 1'b1);
    cyc = 2'b11;
    step();
    check_val("ptr_moved_gnt", gnt_a, 2'b01);

    // both requesting, each holds 3 cycles with ack: grants 0,1,0,1 with one idle cycle
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        cyc = 2'b11;
        step();
      end
      check_val($sformatf("rr%0d_gnt", k), gnt_a, 2'b01 << (k % 2));
      ack = 1'b1;
      stb = 2'b11;
      repeat (2) begin
        step();
        check_val($sformatf("rr%0d_hold", k), gnt_a, 2'b01 << (k % 2));
      end
      cyc = 2'b11 & ~(2'b01 << (k % 2));
      step();
      check_val($sformatf("rr%0d_idle", k), gnt_a, 2'b00);
      check_val($sformatf("rr%0d_noerr", k), te_a, 1'b0);
      ack = 1'b0;
      stb = 2'b00;
    end

    // three masters: wrap-around and skipping of non-requesters
    for (int i = 0; i < 11; i++) begin
      cyc3 = tcyc[i];
      step();
      check_val($sformatf("m3_row%0d", i), gnt_c, texp[i]);
    end
    check_val("m3_idx", idx_c, 2'd1);

    // timeout: 4 stalled strobe edges abort the transfer
    cyc = 2'b01;
    step();
    check_val("to_gnt", gnt_a, 2'b01);
    stb = 2'b01;
    repeat (3) begin
      step();
      check_val("to_pre", te_a, 1'b0);
    end
    step();
    check_val("to_err", te_a, 1'b1);
    check_val("to_count1", cnt_a, 8'd1);
    check_val("to_state", st_a, 2'd2);
    check_val("to_z_state", st_z, 2'd1);
    step();
    check_val("to_pulse_once", te_a, 1'b0);
    check_val("to_abort_gnt", gnt_a, 2'b01);
    cyc = 2'b00;
    stb = 2'b00;
    step();
    check_val("to_rel_state", st_a, 2'd0);
    check_val("to_rel_gnt", gnt_a, 2'b00);

    // low strobe holds the watchdog count
    cyc = 2'b01;
    step();
    stb = 2'b01;
    repeat (3) step();
    stb = 2'b00;
    repeat (2) begin
      step();
      check_val("hold_noerr", te_a, 1'b0);
    end
    stb = 2'b01;
    step();
    check_val("hold_err", te_a, 1'b1);
    check_val("hold_count2", cnt_a, 8'd2);
    cyc = 2'b00;
    stb = 2'b00;
    step();

    // ack on the threshold cycle wins and clears the watchdog
    cyc = 2'b01;
    step();
    stb = 2'b01;
    repeat (3) step();
    ack = 1'b1;
    step();
    check_val("ack_noerr", te_a, 1'b0);
    check_val("ack_state", st_a, 2'd1);
    check_val("ack_gnt", gnt_a, 2'b01);
    ack = 1'b0;
    repeat (3) begin
      step();
      check_val("ack_cleared", te_a, 1'b0);
    end
    step();
    check_val("ack_then_err", te_a, 1'b1);
    check_val("ack_count3", cnt_a, 8'd3);
    ack = 1'b1;
    step();
    check_val("abort_ignores_ack", st_a, 2'd2);
    ack = 1'b0;
    cyc = 2'b00;
    stb = 2'b00;
    step();
    check_val("abort_rel", st_a, 2'd0);

    // reset between edges drops the grant at once
    cyc = 2'b11;
    step();
    check_val("pre_rst_gnt", gnt_a, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_gnt", gnt_a, 2'b00);
    check_val("mid_rst_valid", val_a, 1'b0);
    check_val("mid_rst_count", cnt_a, 8'd0);
    check_val("mid_rst_state", st_a, 2'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check_val("post_rst_gnt", gnt_a, 2'b01);
    check_val("post_rst_z_gnt", gnt_z, 2'b01);

    // watchdog disabled: long stall never aborts
    stb = 2'b01;
    z_err_seen = 0;
    repeat (1000) begin
      step();
      if (te_z) z_err_seen++;
    end
    check_val("wdt_off_errs", z_err_seen, 0);
    check_val("wdt_off_gnt", gnt_z, 2'b01);
    check_val("wdt_off_state", st_z, 2'd1);
    check_val("wdt_off_count", cnt_z, 8'd0);
    check_val("abort_counts_once", cnt_a, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
